// File: rtl/reaper_alu.sv
// reaper_alu: 32-bit signed ALU for the Reaper datapath, outputs registered on Fast_Clock.
// Optional multiply/divide ops are built only when REAPER_ALU_MULDIV_EN is defined.
module reaper_alu (
  input  logic               Fast_Clock,
  input  logic               Reset_N,
  input  logic signed [31:0] Input_1,
  input  logic signed [31:0] Input_2,
  input  logic [4:0]         ALU_Op,
  output logic signed [31:0] Result,
  output logic               True
);

  typedef enum logic [4:0] {
    OP_ADD   = 5'd0,
    OP_SUB   = 5'd1,
    OP_MUL   = 5'd2,
    OP_DIV   = 5'd3,
    OP_MOD   = 5'd4,
    OP_AND   = 5'd5,
    OP_OR    = 5'd6,
    OP_XOR   = 5'd7,
    OP_NOR   = 5'd8,
    OP_NOT   = 5'd9,
    OP_SLL   = 5'd10,
    OP_SRL   = 5'd11,
    OP_SRA   = 5'd12,
    OP_SLT   = 5'd13,
    OP_PASSB = 5'd14,
    OP_NEG   = 5'd15,
    OP_EQ    = 5'd16,
    OP_NE    = 5'd17,
    OP_LT    = 5'd18,
    OP_GT    = 5'd19,
    OP_LE    = 5'd20,
    OP_GE    = 5'd21
  } alu_op_e;

  localparam logic signed [31:0] INT_MIN = 32'sh8000_0000;
  localparam logic signed [31:0] NEG_ONE = -32'sd1;

  alu_op_e            op;
  logic [4:0]         shamt;
  logic signed [31:0] next_result;
  logic               next_true;
  logic               cmp;

  assign op    = alu_op_e'(ALU_Op);
  assign shamt = Input_2[4:0];

  always_comb begin
    next_result = '0;
    next_true   = 1'b0;
    cmp         = 1'b0;
    case (op)
      OP_ADD:   next_result = Input_1 + Input_2;
      OP_SUB:   next_result = Input_1 - Input_2;
`ifdef REAPER_ALU_MULDIV_EN
      OP_MUL:   next_result = Input_1 * Input_2;
      // Zero divisor and the INT_MIN/-1 overflow are resolved before the divider.
      OP_DIV: begin
        if (Input_2 == '0)
          next_result = '0;
        else if (Input_1 == INT_MIN && Input_2 == NEG_ONE)
          next_result = INT_MIN;
        else
          next_result = Input_1 / Input_2;
      end
      OP_MOD: begin
        if (Input_2 == '0 || (Input_1 == INT_MIN && Input_2 == NEG_ONE))
          next_result = '0;
        else
          next_result = Input_1 % Input_2;
      end
`endif
      OP_AND:   next_result = Input_1 & Input_2;
      OP_OR:    next_result = Input_1 | Input_2;
      OP_XOR:   next_result = Input_1 ^ Input_2;
      OP_NOR:   next_result = ~(Input_1 | Input_2);
      OP_NOT:   next_result = ~Input_1;
      OP_SLL:   next_result = Input_1 << shamt;
      OP_SRL:   next_result = $signed($unsigned(Input_1) >> shamt);
      OP_SRA:   next_result = Input_1 >>> shamt;
      OP_SLT:   next_result = {31'b0, (Input_1 < Input_2)};
      OP_PASSB: next_result = Input_2;
      OP_NEG:   next_result = -Input_1;
      OP_EQ, OP_NE, OP_LT, OP_GT, OP_LE, OP_GE: begin
        case (op)
          OP_EQ:   cmp = (Input_1 == Input_2);
          OP_NE:   cmp = (Input_1 != Input_2);
          OP_LT:   cmp = (Input_1 <  Input_2);
          OP_GT:   cmp = (Input_1 >  Input_2);
          OP_LE:   cmp = (Input_1 <= Input_2);
          default: cmp = (Input_1 >= Input_2);
        endcase
        next_result = {31'b0, cmp};
        next_true   = cmp;
      end
      default: begin
        next_result = '0;
        next_true   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Fast_Clock or negedge Reset_N) begin
    if (!Reset_N) begin
      Result <= '0;
      True   <= 1'b0;
    end else begin
      Result <= next_result;
      True   <= next_true;
    end
  end

endmodule

// File: tb/tb_reaper_alu.sv
// Self-checking bench for reaper_alu: vector table through a scoreboard queue,
// plus hand-written reset, back-to-back and mid-cycle input change sequences.
module tb_reaper_alu;

  logic               Fast_Clock = 1'b0;
  logic               Reset_N;
  logic signed [31:0] Input_1;
  logic signed [31:0] Input_2;
  logic [4:0]         ALU_Op;
  logic signed [31:0] Result;
  logic               True;

  reaper_alu dut (
    .Fast_Clock (Fast_Clock),
    .Reset_N    (Reset_N),
    .Input_1    (Input_1),
    .Input_2    (Input_2),
    .ALU_Op     (ALU_Op),
    .Result     (Result),
    .True       (True)
  );

  always #5 Fast_Clock = ~Fast_Clock;

`ifdef REAPER_ALU_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        tf;
    string       name;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        tf;
    string       name;
  } exp_t;

  vec_t tv[$];
  exp_t sb[$];
  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  function automatic void add(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] res, input logic tf, input string name);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.res = res; v.tf = tf; v.name = name;
    tv.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] want_r, input logic want_t);
    n_cmp++;
    if (Result !== want_r || True !== want_t) begin
      n_fail++;
      $display("FAIL %s: got Result=%h True=%b, want Result=%h True=%b",
               name, Result, True, want_r, want_t);
    end
  endtask

  task automatic check_pop();
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.name, e.res, e.tf);
    end
  endtask

  task automatic push(input logic [31:0] res, input logic tf, input string name);
    exp_t e;
    e.res = res; e.tf = tf; e.name = name;
    sb.push_back(e);
  endtask

  task automatic step(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] res, input logic tf, input string name);
    @(negedge Fast_Clock);
    check_pop();
    ALU_Op = op; Input_1 = a; Input_2 = b;
    push(res, tf, name);
  endtask

  task automatic flush();
    @(negedge Fast_Clock);
    check_pop();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    add(5'd0,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, "add_wrap");
    add(5'd1,  32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, "sub_wrap");
    add(5'd15, 32'h80000000, 32'h00000000, 32'h80000000, 1'b0, "neg_min");
    add(5'd15, 32'h00000005, 32'h00000000, 32'hFFFFFFFB, 1'b0, "neg_5");
    add(5'd0,  32'h00000005, 32'h00000003, 32'h00000008, 1'b0, "add_5_3");
    add(5'd1,  32'h00000003, 32'h00000005, 32'hFFFFFFFE, 1'b0, "sub_3_5");
    add(5'd5,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, "and");
    add(5'd6,  32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0, 1'b0, "or");
    add(5'd7,  32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 1'b0, "xor");
    add(5'd8,  32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, "nor_zero");
    add(5'd8,  32'hF0000000, 32'h0000000F, 32'h0FFFFFF0, 1'b0, "nor_mix");
    add(5'd9,  32'h12345678, 32'hFFFFFFFF, 32'hEDCBA987, 1'b0, "not");
    add(5'd12, 32'h80000000, 32'h00000004, 32'hF8000000, 1'b0, "sra_4");
    add(5'd11, 32'h80000000, 32'h00000004, 32'h08000000, 1'b0, "srl_4");
    add(5'd11, 32'h80000000, 32'hFFFFFFE4, 32'h08000000, 1'b0, "srl_hi_b_ignored");
    add(5'd10, 32'h00000001, 32'h00000021, 32'h00000002, 1'b0, "sll_b33");
    add(5'd10, 32'h000000A5, 32'h00000000, 32'h000000A5, 1'b0, "sll_0");
    add(5'd12, 32'h80000000, 32'h00000020, 32'h80000000, 1'b0, "sra_b32_is_0");
    add(5'd12, 32'h80000000, 32'h0000001F, 32'hFFFFFFFF, 1'b0, "sra_31");
    add(5'd12, 32'h40000000, 32'h0000001F, 32'h00000000, 1'b0, "sra_31_pos");
    add(5'd11, 32'h80000000, 32'h0000001F, 32'h00000001, 1'b0, "srl_31");
    add(5'd10, 32'h00000001, 32'h0000001F, 32'h80000000, 1'b0, "sll_31");
    add(5'd13, 32'hFFFFFFFE, 32'h00000003, 32'h00000001, 1'b0, "slt_neg2_3");
    add(5'd13, 32'h00000003, 32'hFFFFFFFE, 32'h00000000, 1'b0, "slt_3_neg2");
    add(5'd13, 32'h00000005, 32'h00000005, 32'h00000000, 1'b0, "slt_eq");
    add(5'd14, 32'h11111111, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, "passb");
    add(5'd16, 32'h00000007, 32'h00000007, 32'h00000001, 1'b1, "eq_7_7");
    add(5'd16, 32'h00000007, 32'h00000008, 32'h00000000, 1'b0, "eq_7_8");
    add(5'd17, 32'h00000007, 32'h00000008, 32'h00000001, 1'b1, "ne_7_8");
    add(5'd17, 32'h00000007, 32'h00000007, 32'h00000000, 1'b0, "ne_7_7");
    add(5'd18, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b1, "lt_m1_1");
    add(5'd18, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b0, "lt_1_m1");
    add(5'd18, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1'b1, "lt_min_max");
    add(5'd19, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, "gt_m1_1");
    add(5'd19, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 1'b1, "gt_1_m1");
    add(5'd20, 32'h00000005, 32'h00000005, 32'h00000001, 1'b1, "le_5_5");
    add(5'd20, 32'h00000006, 32'h00000005, 32'h00000000, 1'b0, "le_6_5");
    add(5'd21, 32'h00000005, 32'h00000005, 32'h00000001, 1'b1, "ge_5_5");
    add(5'd21, 32'hFFFFFFFA, 32'h00000005, 32'h00000000, 1'b0, "ge_m6_5");
    add(5'd21, 32'h80000000, 32'h7FFFFFFF, 32'h00000000, 1'b0, "ge_min_max");
    add(5'd25, 32'h00000009, 32'h00000009, 32'h00000000, 1'b0, "rsvd_25");
    add(5'd22, 32'h00000009, 32'h00000009, 32'h00000000, 1'b0, "rsvd_22");
    add(5'd31, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, "rsvd_31");
    add(5'd2,  32'hFFFFFFFD, 32'h00000004, MD ? 32'hFFFFFFF4 : 32'h0, 1'b0, "mul_m3_4");
    add(5'd2,  32'h00000003, 32'h00000004, MD ? 32'h0000000C : 32'h0, 1'b0, "mul_3_4");
    add(5'd2,  32'h00010001, 32'h00010001, MD ? 32'h00020001 : 32'h0, 1'b0, "mul_wrap");
    add(5'd3,  32'hFFFFFFF9, 32'h00000002, MD ? 32'hFFFFFFFD : 32'h0, 1'b0, "div_m7_2");
    add(5'd3,  32'h00000007, 32'hFFFFFFFE, MD ? 32'hFFFFFFFD : 32'h0, 1'b0, "div_7_m2");
    add(5'd3,  32'h00000064, 32'h00000007, MD ? 32'h0000000E : 32'h0, 1'b0, "div_100_7");
    add(5'd3,  32'h00000005, 32'h00000000, 32'h00000000,              1'b0, "div_by_0");
    add(5'd3,  32'h80000000, 32'hFFFFFFFF, MD ? 32'h80000000 : 32'h0, 1'b0, "div_min_m1");
    add(5'd4,  32'hFFFFFFF9, 32'h00000002, MD ? 32'hFFFFFFFF : 32'h0, 1'b0, "mod_m7_2");
    add(5'd4,  32'h00000007, 32'hFFFFFFFE, MD ? 32'h00000001 : 32'h0, 1'b0, "mod_7_m2");
    add(5'd4,  32'h00000064, 32'h00000007, MD ? 32'h00000002 : 32'h0, 1'b0, "mod_100_7");
    add(5'd4,  32'h00000005, 32'h00000000, 32'h00000000,              1'b0, "mod_by_0");
    add(5'd4,  32'h80000000, 32'hFFFFFFFF, 32'h00000000,              1'b0, "mod_min_m1");

    // Reset held with live inputs: outputs stay cleared across edges.
    Reset_N = 1'b0; Input_1 = 32'd5; Input_2 = 32'd3; ALU_Op = 5'd0;
    repeat (3) @(negedge Fast_Clock);
    chk("reset_hold", 32'h0, 1'b0);
    Reset_N = 1'b1;
    push(32'h00000008, 1'b0, "first_edge_after_reset");

    for (int i = 0; i < tv.size(); i++)
      step(tv[i].op, tv[i].a, tv[i].b, tv[i].res, tv[i].tf, tv[i].name);
    flush();

    // Back-to-back ADD then EQ then ADD.
    step(5'd0,  32'h00000010, 32'h00000020, 32'h00000030, 1'b0, "b2b_add");
    step(5'd16, 32'h00000030, 32'h00000030, 32'h00000001, 1'b1, "b2b_eq");
    step(5'd0,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, "b2b_add2");
    flush();

    // Inputs changed mid-cycle: only the value at the edge counts.
    @(negedge Fast_Clock);
    ALU_Op = 5'd16; Input_1 = 32'd1; Input_2 = 32'd1;
    #2 ALU_Op = 5'd1; Input_1 = 32'd10; Input_2 = 32'd4;
    push(32'h00000006, 1'b0, "midcycle_change");
    flush();

    // Asynchronous reset between edges clears a non-zero result and flag.
    @(negedge Fast_Clock);
    ALU_Op = 5'd16; Input_1 = 32'd7; Input_2 = 32'd7;
    @(posedge Fast_Clock);
    #2 chk("pre_async_reset", 32'h00000001, 1'b1);
    Reset_N = 1'b0;
    #1 chk("async_reset", 32'h0, 1'b0);
    repeat (2) @(negedge Fast_Clock);
    chk("async_reset_hold", 32'h0, 1'b0);
    Reset_N = 1'b1;
    push(32'h00000001, 1'b1, "post_async_reset_edge");
    flush();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/reaper_alu.md
# reaper_alu

32-bit signed arithmetic/logic unit for the Reaper processor datapath. It takes the register-file operand and the register/immediate operand selected by the ALU-source mux, and executes the 5-bit operation from the control module. It returns a 32-bit result, used as the RAM address or register write-back value, and a `True` comparison flag, used by the branch logic. Outputs are registered on the fast clock, so they are settled well before the next slow-clock (processor) edge.

## Interface
Parameters:
- none (width fixed at 32 bits)

Ports (one clock; reset is asynchronous and active-low):
- `Fast_Clock` in, 1: system fast clock; all state updates on its rising edge.
- `Reset_N` in, 1: asynchronous, active-low reset.
- `Input_1` in, 32, signed: operand A (register Data_2).
- `Input_2` in, 32, signed: operand B (register Data_3 or extended immediate).
- `ALU_Op` in, 5: operation select.
- `Result` out, 32, signed: registered operation result.
- `True` out, 1: registered comparison flag.

## Operation
`A` is `Input_1` and `B` is `Input_2`. All arithmetic is two's complement and wraps modulo 2^32.

Operations by `ALU_Op` value:
- 0 ADD: A+B
- 1 SUB: A−B
- 2 MUL: low 32 bits of A×B
- 3 DIV: A/B, signed, truncated toward zero
- 4 MOD: A%B, remainder takes the sign of A
- 5 AND
- 6 OR
- 7 XOR
- 8 NOR
- 9 NOT: ~A
- 10 SLL: A<<B[4:0]
- 11 SRL: logical A>>B[4:0]
- 12 SRA: arithmetic A>>>B[4:0]
- 13 SLT: 1 if A<B, else 0
- 14 PASSB: B (load immediate)
- 15 NEG: −A
- 16 EQ, 17 NE, 18 LT, 19 GT, 20 LE, 21 GE: signed compare.
  - `True` = outcome of the compare.
  - `Result` = {31'b0, outcome}.
- 22–31: reserved; `Result`=0, `True`=0.

Flag and special cases:
- `True` is 0 for every non-compare op, SLT included.
- Division by zero (DIV or MOD with B=0): `Result`=0.
- DIV 0x80000000 / −1 → 0x80000000.
- MOD 0x80000000 % −1 → 0.
- Shift ops ignore B[31:5]. A shift by 0 returns A unchanged.

## Timing
- Next-state values are computed combinationally from the inputs.
- `Result` and `True` register on the rising edge of `Fast_Clock`: latency 1 cycle, throughput 1 op per cycle.
- `Reset_N` low clears `Result` to 0 and `True` to 0 immediately (asynchronous), and holds them there while low.
- The first edge after `Reset_N` rises captures the current inputs normally.
- Inputs are sampled only at the clock edge; glitches between edges have no effect.
- If an op changes mid-cycle, the value registered is the one present at the edge.

## Configuration
- Macro `REAPER_ALU_MULDIV_EN`.
- Defined: MUL, DIV and MOD behave as specified above.
- Undefined: opcodes 2, 3 and 4 are treated as reserved (`Result`=0, `True`=0) and no multiplier or divider logic is synthesized.
- All other ops are identical in both builds.

## Test plan
- Reset: hold `Reset_N`=0 with A=5, B=3, op=0, and clock → `Result`=0, `True`=0. Release reset, one edge → `Result`=8.
- Arithmetic wrap: ADD 0x7FFFFFFF+1 → 0x80000000. SUB 0−1 → 0xFFFFFFFF. NEG 0x80000000 → 0x80000000. All have 1-cycle latency.
- Shifts and logic:
  - SRA 0x80000000 by 4 → 0xF8000000.
  - SRL of the same → 0x08000000.
  - SLL 1 by B=33 → 2 (only B[4:0] is used).
  - NOR 0,0 → 0xFFFFFFFF.
- Compares:
  - LT −1,1 → `True`=1, `Result`=1.
  - GT −1,1 → `True`=0.
  - EQ 7,7 → `True`=1.
  - SLT −2,3 → `Result`=1, `True`=0.
- With `REAPER_ALU_MULDIV_EN` defined:
  - MUL −3×4 → −12.
  - DIV −7/2 → −3.
  - MOD −7%2 → −1.
  - DIV 5/0 → 0.
  - Without the macro, MUL 3×4 → 0.
- Reserved op 25 with A=B=9 → `Result`=0, `True`=0. Back-to-back ops ADD then EQ on consecutive cycles give the correct value at each edge.
